// File: rtl/div_pkg.sv
// Shared constants for the iterative restoring divider: one-hot state encodings,
// their bit indices, and the default operand width.
package div_pkg;
    localparam int DIV_W = 32;

    localparam logic [2:0] S_IDLE = 3'b001;
    localparam logic [2:0] S_CALC = 3'b010;
    localparam logic [2:0] S_FIX  = 3'b100;

    localparam int IDX_IDLE = 0;
    localparam int IDX_CALC = 1;
    localparam int IDX_FIX  = 2;
endpackage

// File: rtl/div_operand_slot.sv
// One-deep AXI-Stream operand buffer. Presents either the held word or, when the
// slot is empty, the word firing this cycle so the consumer can start on the same edge.
module div_operand_slot
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tvalid,
    output logic             o_tready,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_consume,
    output logic             o_avail,
    output logic [WIDTH-1:0] o_data
);
    logic             r_held;
    logic [WIDTH-1:0] r_data;
    logic             w_fire;

    assign o_tready = ~r_held & ~rst;
    assign w_fire   = i_tvalid & o_tready;
    assign o_avail  = r_held | w_fire;
    assign o_data   = r_held ? r_data : i_tdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_held <= 1'b0;
            r_data <= '0;
        end else begin
            // A same-edge fire that is consumed immediately never needs to be held.
            if (i_consume)
                r_held <= 1'b0;
            else if (w_fire)
                r_held <= 1'b1;
            if (w_fire)
                r_data <= i_tdata;
        end
    end
endmodule

// File: rtl/axis_div_core.sv
// Radix-2 restoring divider behind an AXI-Stream dividend/divisor/dout pinout.
// Works on magnitudes for WIDTH cycles, then applies the sign fix-up in one FIX cycle.
module axis_div_core
    import div_pkg::*;
#(
    parameter int WIDTH  = DIV_W,
    parameter bit SIGNED = 1'b1
) (
    input  logic               aclk,
    input  logic               reset,
    input  logic               s_axis_dividend_tvalid,
    output logic               s_axis_dividend_tready,
    input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
    input  logic               s_axis_divisor_tvalid,
    output logic               s_axis_divisor_tready,
    input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
    output logic               m_axis_dout_tvalid,
    output logic [2*WIDTH-1:0] m_axis_dout_tdata
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Index 0 is the dividend channel, index 1 the divisor channel.
    logic             w_tvalid [2];
    logic             w_tready [2];
    logic [WIDTH-1:0] w_tdata  [2];
    logic             w_avail  [2];
    logic [WIDTH-1:0] w_opnd   [2];
    logic             w_neg    [2];
    logic [WIDTH-1:0] w_mag    [2];

    logic [2:0]       r_state;
    logic [2:0]       w_state_next;
    logic             w_start;
    logic             w_step;
    logic             w_fix;

    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_dz;
    logic             r_tvalid;
    logic [2*WIDTH-1:0] r_tdata;

    logic [WIDTH:0]   w_rem_shift;
    logic [WIDTH:0]   w_rem_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    assign w_tvalid[0] = s_axis_dividend_tvalid;
    assign w_tvalid[1] = s_axis_divisor_tvalid;
    assign w_tdata[0]  = s_axis_dividend_tdata;
    assign w_tdata[1]  = s_axis_divisor_tdata;
    assign s_axis_dividend_tready = w_tready[0];
    assign s_axis_divisor_tready  = w_tready[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            div_operand_slot #(.WIDTH(WIDTH)) u_slot (
                .clk       (aclk),
                .rst       (reset),
                .i_tvalid  (w_tvalid[gi]),
                .o_tready  (w_tready[gi]),
                .i_tdata   (w_tdata[gi]),
                .i_consume (w_start),
                .o_avail   (w_avail[gi]),
                .o_data    (w_opnd[gi])
            );
            assign w_neg[gi] = SIGNED && w_opnd[gi][WIDTH-1];
            assign w_mag[gi] = w_neg[gi] ? -w_opnd[gi] : w_opnd[gi];
        end
    endgenerate

    always_ff @(posedge aclk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_next = S_CALC;
            S_CALC:  if (r_cnt == CNT_LAST) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_start = r_state[IDX_IDLE] & w_avail[0] & w_avail[1];
        w_step  = r_state[IDX_CALC];
        w_fix   = r_state[IDX_FIX];
    end

    // Compare is one bit wider than the operands so a full-scale divisor still works.
    assign w_rem_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_rem_diff  = w_rem_shift - {1'b0, r_div};
    assign w_ge        = (w_rem_shift >= {1'b0, r_div});

    // With a zero divisor the remainder magnitude equals |dividend|, so its sign fix
    // alone reproduces the dividend; only the quotient needs forcing.
    assign w_quo_fix = r_dz ? '1 : (r_sign_q ? -r_quo : r_quo);
    assign w_rem_fix = r_sign_r ? -r_rem : r_rem;

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_dz     <= 1'b0;
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
        end else begin
            r_tvalid <= w_fix;
            if (w_start) begin
                r_cnt    <= '0;
                r_rem    <= '0;
                r_quo    <= w_mag[0];
                r_div    <= w_mag[1];
                r_sign_q <= w_neg[0] ^ w_neg[1];
                r_sign_r <= w_neg[0];
                r_dz     <= (w_opnd[1] == '0);
            end else if (w_step) begin
                r_cnt <= r_cnt + CNT_W'(1);
                r_rem <= w_ge ? w_rem_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], w_ge};
            end else if (w_fix) begin
                r_tdata <= {w_quo_fix, w_rem_fix};
            end
        end
    end

    assign m_axis_dout_tvalid = r_tvalid;
    assign m_axis_dout_tdata  = r_tdata;
endmodule
